// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin arbiter for the single register-file write port with a registered output stage
module regfile_wr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NREQ-1:0]    req_v_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    output logic [NREQ-1:0]    req_rdy_o,
    input  logic               wr_stall_i,
    output logic               wr_en_o,
    output logic [AW-1:0]      wr_addr_o,
    output logic [DW-1:0]      wr_data_o,
    output logic [2**AW-1:0]   wr_sel_o,
    output logic [2:0]         gnt_id_o
);

    localparam int NS = 2**AW;

    // The stage is either empty or holds a write; WRITE vs HOLD is decided
    // live by wr_stall_i, so only occupancy needs to be registered.
    typedef enum logic {S_IDLE, S_FULL} state_e;

    state_e          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [NS-1:0]   sel_q, sel_d;
    logic [2:0]      gid_q, gid_d;

    logic            can_load;
    logic            hit;
    logic            grant;
    logic [NREQ-1:0] rot;
    logic [3:0]      sum;
    logic [3:0]      win;
    logic [3:0]      nxt;
    logic [NREQ-1:0] rdy;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;

    assign can_load = (state_q == S_IDLE) || !wr_stall_i;

    // Rotate requests so the pointer sits at bit 0, then take the first set bit
    always_comb begin
        rot = NREQ'({req_v_i, req_v_i} >> ptr_q);
        hit = 1'b0;
        sum = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!hit && rot[j]) begin
                hit = 1'b1;
                sum = {1'b0, ptr_q} + 4'(j);
            end
        end
        win   = (sum >= 4'(NREQ)) ? sum - 4'(NREQ) : sum;
        nxt   = win + 4'd1;
        grant = hit && can_load && !rst_i;
    end

    // One-hot ready and the winner's address/data mux
    always_comb begin
        rdy      = '0;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            rdy[i] = grant && (win == 4'(i));
            if (win == 4'(i)) begin
                win_addr = req_addr_i[i*AW +: AW];
                win_data = req_data_i[i*DW +: DW];
            end
        end
    end

    assign req_rdy_o = rdy;

    // Next state of the output stage and the priority pointer
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        gid_d   = gid_q;
        if (can_load) begin
            if (grant) begin
                state_d = S_FULL;
                addr_d  = win_addr;
                data_d  = win_data;
                sel_d   = NS'(1) << win_addr;
                gid_d   = win[2:0];
                ptr_d   = (nxt == 4'(NREQ)) ? 3'd0 : nxt[2:0];
            end else begin
                state_d = S_IDLE;
                sel_d   = '0;
            end
        end
    end

    // Output stage and pointer registers; reset discards any pending write
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            gid_q   <= gid_d;
        end
    end

    assign wr_en_o   = (state_q == S_FULL);
    assign wr_addr_o = addr_q;
    assign wr_data_o = data_q;
    assign wr_sel_o  = sel_q;
    assign gnt_id_o  = gid_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed and randomized checks of the write-port arbiter against a behavioural model
module tb_regfile_wr_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_v = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_rdy;
    logic            stall = 1'b0;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [31:0]     wr_sel;
    logic [2:0]      gnt_id;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_v_i(req_v), .req_addr_i(req_addr), .req_data_i(req_data),
        .req_rdy_o(req_rdy), .wr_stall_i(stall),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .wr_sel_o(wr_sel), .gnt_id_o(gnt_id)
    );

    int n_chk = 0;
    int n_pass = 0;

    // requester-side pending requests
    bit            pv[N];
    logic [AW-1:0] pa[N];
    logic [DW-1:0] pd[N];

    // reference model of the output stage
    bit            m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_gid;
    int            m_ptr;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int m_win();
        if (m_en && stall) return -1;
        for (int k = 0; k < N; k++)
            if (pv[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic chk_out(string tag);
        chk({tag, "_en"},   32'(wr_en),   32'(m_en));
        chk({tag, "_addr"}, 32'(wr_addr), 32'(m_addr));
        chk({tag, "_data"}, 32'(wr_data), 32'(m_data));
        chk({tag, "_sel"},  wr_sel,       m_en ? (32'd1 << m_addr) : 32'd0);
        chk({tag, "_gid"},  32'(gnt_id),  32'(m_gid));
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_v[i]             = pv[i];
            req_addr[i*AW +: AW] = pa[i];
            req_data[i*DW +: DW] = pd[i];
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_addr = '0; m_data = '0; m_gid = 0; m_ptr = 0;
        for (int i = 0; i < N; i++) pv[i] = 0;
    endtask

    task automatic step(output int w);
        drive();
        #1;
        w = m_win();
        chk("rdy", 32'(req_rdy), (w < 0) ? 32'd0 : (32'd1 << w));
        @(posedge clk);
        if (!m_en || !stall) begin
            if (w >= 0) begin
                m_en = 1; m_addr = pa[w]; m_data = pd[w]; m_gid = w;
                m_ptr = (w + 1) % N; pv[w] = 0;
            end else m_en = 0;
        end
        @(negedge clk);
        chk_out("out");
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_en",   32'(wr_en),   32'd0);
        chk("rst_sel",  wr_sel,       32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        chk("rst_gid",  32'(gnt_id),  32'd0);
        chk("rst_rdy",  32'(req_rdy), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_req(int i, logic [AW-1:0] a, logic [DW-1:0] d);
        pv[i] = 1; pa[i] = a; pd[i] = d;
    endtask

    initial begin
        int w;
        model_reset();
        for (int i = 0; i < N; i++) begin pa[i] = '0; pd[i] = '0; end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) step(w);
        do_reset();
        repeat (2) step(w);

        set_req(2, 5'd17, 8'hA5);
        drive(); #1;
        chk("t2_rdy", 32'(req_rdy), 32'h4);
        step(w);
        chk("t2_sel", wr_sel, 32'h0002_0000);
        chk("t2_data", 32'(wr_data), 32'hA5);
        chk("t2_gid", 32'(gnt_id), 32'd2);

        set_req(0, 5'($urandom), 8'($urandom));
        set_req(1, 5'($urandom), 8'($urandom));
        step(w);
        chk("t6_wrap_gid", 32'(gnt_id), 32'd0);
        step(w);
        chk("t6_next_gid", 32'(gnt_id), 32'd1);

        set_req(2, 5'd5, 8'h3C);
        step(w);
        chk("t4_load_addr", 32'(wr_addr), 32'd5);
        set_req(0, 5'd12, 8'h11);
        set_req(1, 5'd13, 8'h22);
        stall = 1'b1;
        repeat (3) begin
            step(w);
            chk("t4_hold_addr", 32'(wr_addr), 32'd5);
            chk("t4_hold_rdy", 32'(req_rdy), 32'd0);
        end
        stall = 1'b0;
        drive(); #1;
        chk("t4_release_rdy", 32'(req_rdy), 32'h1);
        step(w);
        chk("t4_release_gid", 32'(gnt_id), 32'd0);
        step(w);
        step(w);

        set_req(3, 5'd9, 8'h99);
        step(w);
        stall = 1'b1;
        step(w);
        chk("t5_hold_addr", 32'(wr_addr), 32'd9);
        do_reset();
        repeat (2) begin
            step(w);
            chk("t5_no_write", 32'(wr_en), 32'd0);
        end
        set_req(1, 5'd31, 8'h5A);
        step(w);
        chk("idle_stall_gid", 32'(gnt_id), 32'd1);
        chk("idle_stall_sel", wr_sel, 32'h8000_0000);
        stall = 1'b0;
        step(w);

        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 5'($urandom), 8'($urandom));
        for (int k = 0; k < 5; k++) begin
            step(w);
            chk("t3_gid", 32'(gnt_id), 32'(k % N));
            chk("t3_en", 32'(wr_en), 32'd1);
            if (w >= 0) set_req(w, 5'($urandom), 8'($urandom));
        end
        for (int i = 0; i < N; i++) pv[i] = 0;
        step(w);

        for (int c = 0; c < 600; c++) begin
            stall = ($urandom_range(0, 9) < 3);
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && ($urandom_range(0, 2) == 0)) set_req(i, 5'($urandom), 8'($urandom));
                else if (pv[i] && ($urandom_range(0, 15) == 0)) pv[i] = 0;
            end
            step(w);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
